dct_sequencer: RTL and testbench

- Controller that turns one frame of NUM_FILTERS log-mel energies into NUM_CEPS cepstral coefficients.
- Buffers the input frame and sequences a single shared signed MAC across all (n, k) pairs.
- Drives the address of the external Q15 cosine ROM (NUM_FILTERS x NUM_CEPS, 1-cycle read latency).
- Sits between the log/mel stage and the MFCC output stage; valid/ready on both sides.

---
 rtl/dct_sequencer_if.sv | 49 ++++
 rtl/dct_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_dct_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/dct_sequencer_if.sv
// -----------------------------------------------------------------------------
// dct_sequencer_if
//   Bundles every non-clock/reset signal of dct_sequencer.
//   slave  : the sequencer itself.
//   master : the environment (log/mel source, cosine ROM, MFCC sink).
//   Signals:
//     in_valid/in_ready/in_data        sample stream from the log/mel stage
//     rom_en/rom_addr_n/rom_addr_k     cosine ROM read request
//     rom_data                         ROM word, one cycle after rom_en
//     out_valid/out_ready/out_data     coefficient stream to the MFCC stage
//     out_index/out_last               k of out_data, final coefficient marker
//     sat_flag/busy                    per-frame saturation, activity status
// -----------------------------------------------------------------------------
interface dct_sequencer_if #(
  parameter int NUM_FILTERS = 40,
  parameter int NUM_CEPS    = 12,
  parameter int DATA_WIDTH  = 16,
  parameter int COEF_WIDTH  = 16
);
  localparam int N_W = $clog2(NUM_FILTERS);
  localparam int K_W = $clog2(NUM_CEPS);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         rom_en;
  logic [N_W-1:0]               rom_addr_n;
  logic [K_W-1:0]               rom_addr_k;
  logic signed [COEF_WIDTH-1:0] rom_data;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic [K_W-1:0]               out_index;
  logic                         out_last;
  logic                         sat_flag;
  logic                         busy;

  modport slave (
    input  in_valid, in_data, rom_data, out_ready,
    output in_ready, rom_en, rom_addr_n, rom_addr_k,
           out_valid, out_data, out_index, out_last, sat_flag, busy
  );

  modport master (
    output in_valid, in_data, rom_data, out_ready,
    input  in_ready, rom_en, rom_addr_n, rom_addr_k,
           out_valid, out_data, out_index, out_last, sat_flag, busy
  );
endinterface

// File: rtl/dct_sequencer.sv
// -----------------------------------------------------------------------------
// dct_sequencer
//   Buffers one frame of NUM_FILTERS log-mel samples, then computes the
//   cepstral coefficients k = K0..NUM_CEPS-1 with one shared signed MAC,
//   reading the Q15 cosine table from an external 1-cycle-latency ROM.
//   Each coefficient is rounded (acc + 2^14) >>> 15 and saturated to
//   DATA_WIDTH bits before being offered on the output handshake.
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset (aborts any frame in progress)
//     bus  dct_sequencer_if.slave (input stream, ROM port, output stream,
//          sat_flag, busy)
//
//   Build option:
//     DCT_SKIP_C0_EN  when defined, k=0 (frame energy) is skipped and each
//                     frame emits only k = 1..NUM_CEPS-1.
// -----------------------------------------------------------------------------
module dct_sequencer #(
  parameter int NUM_FILTERS = 40,
  parameter int NUM_CEPS    = 12,
  parameter int DATA_WIDTH  = 16,
  parameter int COEF_WIDTH  = 16,
  parameter int ACC_WIDTH   = 40
) (
  input  logic            clk,
  input  logic            rst,
  dct_sequencer_if.slave  bus
);
  localparam int N_W = $clog2(NUM_FILTERS);
  localparam int K_W = $clog2(NUM_CEPS);
  localparam int C_W = $clog2(NUM_FILTERS + 1);
  localparam int P_W = DATA_WIDTH + COEF_WIDTH;

`ifdef DCT_SKIP_C0_EN
  localparam logic [K_W-1:0] K0 = K_W'(1);
`else
  localparam logic [K_W-1:0] K0 = '0;
`endif

  localparam logic [C_W-1:0] C_LOAD_LAST = C_W'(NUM_FILTERS - 1);
  localparam logic [C_W-1:0] C_MAC_LAST  = C_W'(NUM_FILTERS);
  localparam logic [K_W-1:0] K_LAST      = K_W'(NUM_CEPS - 1);

  localparam logic signed [ACC_WIDTH-1:0] RND     = ACC_WIDTH'(16384);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_OUTPUT  = 2'd2;

  logic [1:0]                   state_q, state_d;
  logic [C_W-1:0]               cnt_q, cnt_d;      // sample index in LOAD, cycle index in COMPUTE
  logic [K_W-1:0]               k_q, k_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] sample_q, sample_d;
  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                         sat_q, sat_d;
  logic signed [DATA_WIDTH-1:0] smp_buf_q [NUM_FILTERS];

  logic                         load_fire;
  logic                         rom_rd;
  logic [NUM_FILTERS-1:0]       buf_we;
  logic signed [P_W-1:0]        prod;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic signed [ACC_WIDTH-1:0]  rnd_sum;
  logic signed [ACC_WIDTH-1:0]  scaled;

  assign load_fire = (state_q == ST_LOAD) && bus.in_valid;
  // The final COMPUTE cycle only folds in the last ROM word; no new read.
  assign rom_rd    = (state_q == ST_COMPUTE) && (cnt_q != C_MAC_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FILTERS; gi++) begin : g_we
      assign buf_we[gi] = load_fire && (cnt_q == C_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_FILTERS; i++) smp_buf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_FILTERS; i++) begin
        if (buf_we[i]) smp_buf_q[i] <= bus.in_data;
      end
    end
  end

  // The sample is read one cycle early so it lines up with the ROM word
  // returned for the same n.
  always_comb begin
    sample_d = sample_q;
    if (rom_rd) sample_d = smp_buf_q[cnt_q[N_W-1:0]];
  end

  assign prod    = P_W'(sample_q) * P_W'(bus.rom_data);
  assign acc_sum = acc_q + $signed({{(ACC_WIDTH-P_W){prod[P_W-1]}}, prod});
  assign rnd_sum = acc_sum + RND;
  assign scaled  = rnd_sum >>> 15;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    sat_d      = sat_q;
    case (state_q)
      ST_LOAD: begin
        if (bus.in_valid) begin
          if (cnt_q == '0) sat_d = 1'b0;
          if (cnt_q == C_LOAD_LAST) begin
            state_d = ST_COMPUTE;
            cnt_d   = '0;
            k_d     = K0;
            acc_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        // Cycle 0 only issues the first ROM read; data arrives from cycle 1.
        if (cnt_q != '0) acc_d = acc_sum;
        if (cnt_q == C_MAC_LAST) begin
          state_d = ST_OUTPUT;
          cnt_d   = '0;
          if (scaled > SAT_MAX) begin
            out_data_d = SAT_MAX[DATA_WIDTH-1:0];
            sat_d      = 1'b1;
          end else if (scaled < SAT_MIN) begin
            out_data_d = SAT_MIN[DATA_WIDTH-1:0];
            sat_d      = 1'b1;
          end else begin
            out_data_d = scaled[DATA_WIDTH-1:0];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_OUTPUT: begin
        if (bus.out_ready) begin
          if (k_q == K_LAST) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_COMPUTE;
            k_d     = k_q + 1'b1;
            acc_d   = '0;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      sample_q   <= '0;
      out_data_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      sample_q   <= sample_d;
      out_data_q <= out_data_d;
      sat_q      <= sat_d;
    end
  end

  // Outputs are decoded from state so an asynchronous reset clears them
  // immediately; index/data read as 0 whenever no coefficient is offered.
  assign bus.in_ready   = (state_q == ST_LOAD);
  assign bus.busy       = (state_q != ST_LOAD);
  assign bus.rom_en     = rom_rd;
  assign bus.rom_addr_n = rom_rd ? cnt_q[N_W-1:0] : '0;
  assign bus.rom_addr_k = rom_rd ? k_q : '0;
  assign bus.out_valid  = (state_q == ST_OUTPUT);
  assign bus.out_data   = (state_q == ST_OUTPUT) ? out_data_q : '0;
  assign bus.out_index  = (state_q == ST_OUTPUT) ? k_q : '0;
  assign bus.out_last   = (state_q == ST_OUTPUT) && (k_q == K_LAST);
  assign bus.sat_flag   = sat_q;
endmodule

// File: tb/tb_dct_sequencer.sv
module tb_dct_sequencer;
  localparam int NF = 40;
  localparam int NC = 12;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int AW = 40;
`ifdef DCT_SKIP_C0_EN
  localparam int K0 = 1;
`else
  localparam int K0 = 0;
`endif
  localparam int COEF_LAT  = NF + 1;
  localparam int FRAME_CYC = (NC - K0) * (NF + 2);
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;

  dct_sequencer_if #(.NUM_FILTERS(NF), .NUM_CEPS(NC), .DATA_WIDTH(DW), .COEF_WIDTH(CW)) bus ();

  dct_sequencer #(
    .NUM_FILTERS(NF), .NUM_CEPS(NC), .DATA_WIDTH(DW), .COEF_WIDTH(CW), .ACC_WIDTH(AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cosine ROM model: Q15 table, one cycle read latency.
  int rom [NF][NC];
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= CW'(rom[bus.rom_addr_n][bus.rom_addr_k]);
  end

  int  n_checks = 0;
  int  n_fail   = 0;
  int  x [NF];
  int  exp_d [NC];
  bit  exp_s [NC];
  int  t_accept;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: direct dot product, Q15 rounding and saturation.
  task automatic compute_expected();
    for (int k = 0; k < NC; k++) begin
      longint acc;
      longint r;
      acc = 0;
      for (int n = 0; n < NF; n++) acc += longint'(x[n]) * longint'(rom[n][k]);
      r = (acc + 64'sd16384) >>> 15;
      exp_s[k] = (r > 32767) || (r < -32768);
      exp_d[k] = (r > 32767) ? 32767 : ((r < -32768) ? -32768 : int'(r));
    end
  endtask

  task automatic send_frame();
    for (int n = 0; n < NF; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin @(posedge clk); #1; end
      if (n == 0) check("in_ready_load", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(x[n]);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
    t_accept = cyc;
  endtask

  task automatic recv_frame(input int stall_k, input int abort_k);
    int t_ref;
    bit sat_seen;
    t_ref    = t_accept;
    sat_seen = 1'b0;
    for (int k = K0; k < NC; k++) begin
      int waited;
      if (k == abort_k) begin
        repeat (10) begin @(posedge clk); #1; end
        check("abort_busy", bus.busy, 1);
        check("abort_rom_en", bus.rom_en, 1);
        check("abort_rom_n", bus.rom_addr_n, 10);
        check("abort_rom_k", bus.rom_addr_k, k);
        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_rom_en", bus.rom_en, 0);
        check("rst_rom_n", bus.rom_addr_n, 0);
        check("rst_rom_k", bus.rom_addr_k, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_index", bus.out_index, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_sat", bus.sat_flag, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (k == stall_k) bus.out_ready = 1'b0;
      waited = 0;
      while (bus.out_valid !== 1'b1 && waited < 200) begin
        @(posedge clk); #1;
        waited++;
      end
      if (bus.out_valid !== 1'b1) begin
        check("out_valid_timeout", bus.out_valid, 1);
        return;
      end
      sat_seen |= exp_s[k];
      check("latency", cyc - t_ref, COEF_LAT);
      check("out_data", bus.out_data, exp_d[k]);
      check("out_index", bus.out_index, k);
      check("out_last", bus.out_last, (k == NC - 1));
      check("sat_running", bus.sat_flag, sat_seen);
      if (k == stall_k) begin
        for (int i = 0; i < 20; i++) begin
          bus.in_valid = ($urandom_range(0, 1) == 1);
          bus.in_data  = DW'($urandom);
          @(posedge clk); #1;
          check("stall_valid", bus.out_valid, 1);
          check("stall_data", bus.out_data, exp_d[k]);
          check("stall_index", bus.out_index, k);
          check("stall_rom_en", bus.rom_en, 0);
          check("stall_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      t_ref = cyc;
    end
    check("frame_end_valid", bus.out_valid, 0);
    check("frame_end_in_ready", bus.in_ready, 1);
    check("frame_sat", bus.sat_flag, sat_seen);
    if (stall_k < 0) check("frame_time", cyc - t_accept, FRAME_CYC);
  endtask

  task automatic run_frame(input int stall_k, input int abort_k);
    compute_expected();
    send_frame();
    recv_frame(stall_k, abort_k);
  endtask

  initial begin
    for (int n = 0; n < NF; n++)
      for (int k = 0; k < NC; k++)
        rom[n][k] = $rtoi($floor(32767.0 * $cos(PI * k * (n + 0.5) / NF) + 0.5));

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_rom_en", bus.rom_en, 0);
    check("reset_sat", bus.sat_flag, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_out_last", bus.out_last, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Constant input
    for (int n = 0; n < NF; n++) x[n] = 100;
    run_frame(-1, -1);

    // Impulse
    for (int n = 0; n < NF; n++) x[n] = (n == 0) ? 16384 : 0;
    run_frame(-1, -1);

    // Full-scale input, saturates k=0
    for (int n = 0; n < NF; n++) x[n] = 32767;
    run_frame(-1, -1);

    // All zeros clears sat_flag
    for (int n = 0; n < NF; n++) x[n] = 0;
    run_frame(-1, -1);

    // Random frame with backpressure at k=3
    for (int n = 0; n < NF; n++) x[n] = int'($urandom_range(0, 65535)) - 32768;
    run_frame(3, -1);

    // Random frame aborted by reset during k=5
    for (int n = 0; n < NF; n++) x[n] = int'($urandom_range(0, 65535)) - 32768;
    run_frame(-1, 5);

    // Constant frame after reset reproduces the first results
    for (int n = 0; n < NF; n++) x[n] = 100;
    run_frame(-1, -1);

    // Random moderate-amplitude frames
    for (int f = 0; f < 2; f++) begin
      for (int n = 0; n < NF; n++) x[n] = int'($urandom_range(0, 4095)) - 2048;
      run_frame(-1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
